tick_decoder: RTL
=================

TICK_DECODER -- requirements
Module: tick_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the statistics counters (used only when TICK_DECODER_STATS_EN is defined).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port s_valid, input, 1, feed byte present this cycle; there is no ready, so every valid byte is consumed.
REQ-005 SHALL have port s_data, input, 8, feed byte.
REQ-006 SHALL have port s_last, input, 1, marks the final byte of a message.
REQ-007 SHALL have port tick_valid, output, 1, one-cycle pulse for a decoded tick; drives the L1 book.
REQ-008 SHALL have port tick_type, output, 1, 0 = Add, 1 = Exec.
REQ-009 SHALL have port tick_side, output, 1, 1 = Buy, 0 = Sell.
REQ-010 SHALL have port tick_qty, output, 32, quantity.
REQ-011 SHALL have port tick_price, output, 32, price.
REQ-012 SHALL have ports msg_count and drop_count, output, CNT_W each, present only under TICK_DECODER_STATS_EN.

Function
REQ-013 SHALL accept a message of exactly 10 bytes.
- Byte 0: type, 0x41 'A' = Add, 0x45 'E' = Exec.
- Byte 1: side, 0x42 'B' = Buy, 0x53 'S' = Sell.
- Bytes 2-5: qty, big-endian.
- Bytes 6-9: price, big-endian.
- s_last is set on byte 9 only.
REQ-014 SHALL implement states IDLE, BODY and DISCARD, plus a 4-bit byte index that advances only on s_valid cycles.
REQ-015 IDLE transitions:
- Valid type byte without s_last -> BODY, index 1.
- Invalid type byte without s_last -> DISCARD.
- Any byte with s_last -> drop, stay in IDLE.
REQ-016 BODY transitions:
- Invalid side byte -> DISCARD, or drop and go to IDLE if s_last is set.
- s_last on index < 9 -> drop, go to IDLE.
- Index 9 without s_last -> DISCARD.
- Index 9 with s_last -> emit tick, go to IDLE.
REQ-017 DISCARD SHALL ignore bytes until one arrives with s_last, then return to IDLE; each malformed message counts exactly one drop.
REQ-018 SHALL assert tick_valid for exactly one cycle, in the cycle after byte 9 is accepted (latency 1), with all tick fields valid in that same cycle.
REQ-019 SHALL hold tick_type, tick_side, tick_qty and tick_price stable until the next emitted tick; dropped messages SHALL NOT alter them.
REQ-020 SHALL accept the type byte of the next message in the cycle immediately after an s_last byte, so back-to-back messages lose no cycles.
REQ-021 SHALL treat s_valid low as a stall: no state or index change, and no timeout.
REQ-022 SHALL ignore s_data and s_last while s_valid is low.

Reset
REQ-023 On rst, SHALL return to IDLE with index 0.
REQ-024 On rst, SHALL clear tick_valid, tick_type, tick_side, tick_qty, tick_price and the counters to 0.
REQ-025 rst mid-message SHALL discard the partial message without a drop count; the first valid byte after rst deasserts is a type byte.
REQ-026 rst SHALL take priority over any input in the same cycle.

Configuration
REQ-027 With TICK_DECODER_STATS_EN defined:
- msg_count increments on each emitted tick.
- drop_count increments on each dropped message.
- Both saturate at all-ones.
REQ-028 Without TICK_DECODER_STATS_EN, SHALL omit the counter ports and logic, with decode behaviour identical.

Verification
REQ-029 Send 41 42 00 00 00 64 00 00 27 10 (last on byte 9) -> one tick_valid pulse, 1 cycle after the last byte, with type 0, side 1, qty 100, price 10000.
REQ-030 Send 45 53 00 00 00 05 00 00 27 11 back-to-back with the REQ-029 message, no gaps -> two pulses 10 cycles apart; the second has type 1, side 0, qty 5, price 10001.
REQ-031 Send the REQ-029 message with s_valid low for 3 cycles between bytes 4 and 5 -> identical tick, delayed 3 cycles.
REQ-032 Send a message with type 0x58, then a 6-byte message with last on byte 5, then a 12-byte message -> no tick_valid, previous tick fields unchanged, drop_count = 3 (STATS_EN).
REQ-033 Send bytes 0-4 of a valid message, then rst for 1 cycle, then a full valid message -> exactly one tick, matching the second message; drop_count = 0.

Source files
------------

// File: rtl/tick_decoder.sv
// Decodes 10-byte Add/Exec feed messages into single-cycle ticks for the L1 book.
// Latency 1 cycle from last byte to tick_valid; no backpressure, every valid byte is consumed.
// Optional saturating msg/drop counters are compiled in with TICK_DECODER_STATS_EN.
module tick_decoder #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        tick_valid,
    output logic        tick_type,
    output logic        tick_side,
    output logic [31:0] tick_qty,
    output logic [31:0] tick_price
`ifdef TICK_DECODER_STATS_EN
    ,
    output logic [CNT_W-1:0] msg_count,
    output logic [CNT_W-1:0] drop_count
`endif
);

    typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        typ_q, typ_d;
    logic        side_q, side_d;
    logic [31:0] qty_q, qty_d;
    logic [31:0] price_q, price_d;

    logic        tick_valid_q, tick_valid_d;
    logic        tick_type_q, tick_type_d;
    logic        tick_side_q, tick_side_d;
    logic [31:0] tick_qty_q, tick_qty_d;
    logic [31:0] tick_price_q, tick_price_d;

    logic        emit;
    logic        drop;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        typ_d        = typ_q;
        side_d       = side_q;
        qty_d        = qty_q;
        price_d      = price_q;
        tick_valid_d = 1'b0;
        tick_type_d  = tick_type_q;
        tick_side_d  = tick_side_q;
        tick_qty_d   = tick_qty_q;
        tick_price_d = tick_price_q;
        emit         = 1'b0;
        drop         = 1'b0;

        if (s_valid) begin
            case (state_q)
                IDLE: begin
                    if (s_last) begin
                        drop = 1'b1;
                    end else if (s_data == 8'h41 || s_data == 8'h45) begin
                        state_d = BODY;
                        idx_d   = 4'd1;
                        typ_d   = (s_data == 8'h45);
                    end else begin
                        state_d = DISCARD;
                    end
                end
                BODY: begin
                    idx_d = idx_q + 4'd1;
                    if (idx_q == 4'd1)
                        side_d = (s_data == 8'h42);
                    if (idx_q >= 4'd2 && idx_q <= 4'd5)
                        qty_d = {qty_q[23:0], s_data};
                    if (idx_q >= 4'd6 && idx_q <= 4'd9)
                        price_d = {price_q[23:0], s_data};

                    if (idx_q == 4'd1 && s_data != 8'h42 && s_data != 8'h53) begin
                        idx_d = 4'd0;
                        if (s_last) begin
                            drop    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DISCARD;
                        end
                    end else if (s_last) begin
                        idx_d   = 4'd0;
                        state_d = IDLE;
                        if (idx_q == 4'd9)
                            emit = 1'b1;
                        else
                            drop = 1'b1;
                    end else if (idx_q == 4'd9) begin
                        // Overlong message: the drop is counted when its s_last finally arrives.
                        idx_d   = 4'd0;
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (s_last) begin
                        drop    = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                end
            endcase
        end

        if (emit) begin
            tick_valid_d = 1'b1;
            tick_type_d  = typ_q;
            tick_side_d  = side_q;
            tick_qty_d   = qty_q;
            tick_price_d = {price_q[23:0], s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            typ_q        <= 1'b0;
            side_q       <= 1'b0;
            qty_q        <= 32'd0;
            price_q      <= 32'd0;
            tick_valid_q <= 1'b0;
            tick_type_q  <= 1'b0;
            tick_side_q  <= 1'b0;
            tick_qty_q   <= 32'd0;
            tick_price_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            typ_q        <= typ_d;
            side_q       <= side_d;
            qty_q        <= qty_d;
            price_q      <= price_d;
            tick_valid_q <= tick_valid_d;
            tick_type_q  <= tick_type_d;
            tick_side_q  <= tick_side_d;
            tick_qty_q   <= tick_qty_d;
            tick_price_q <= tick_price_d;
        end
    end

    assign tick_valid = tick_valid_q;
    assign tick_type  = tick_type_q;
    assign tick_side  = tick_side_q;
    assign tick_qty   = tick_qty_q;
    assign tick_price = tick_price_q;

`ifdef TICK_DECODER_STATS_EN
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        msg_cnt_d  = msg_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (emit && msg_cnt_q != {CNT_W{1'b1}})
            msg_cnt_d = msg_cnt_q + 1'b1;
        if (drop && drop_cnt_q != {CNT_W{1'b1}})
            drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            msg_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            msg_cnt_q  <= msg_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign msg_count  = msg_cnt_q;
    assign drop_count = drop_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = drop ^ (CNT_W > 0);
`endif

endmodule
